// File: rtl/ddr3_wr_gearbox.sv
// BL8 write-burst FIFO and x4 gearing serializer for DQ/DQS (and DM when DDR3_WR_DM_EN
// is defined), with one-SCLK DQS preamble/postamble. Single SCLK domain.
module ddr3_wr_gearbox #(
   parameter int DQ_WIDTH   = 16,
   parameter int FIFO_DEPTH = 4,
   localparam int DM_WIDTH  = DQ_WIDTH / 8,
   localparam int DQS_WIDTH = DQ_WIDTH / 8
) (
   input  logic                  sclk,
   input  logic                  rstb,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [8*DQ_WIDTH-1:0] wr_data,
`ifdef DDR3_WR_DM_EN
   input  logic [8*DM_WIDTH-1:0] wr_mask,
   output logic [DM_WIDTH-1:0]   dm_d0,
   output logic [DM_WIDTH-1:0]   dm_d1,
   output logic [DM_WIDTH-1:0]   dm_d2,
   output logic [DM_WIDTH-1:0]   dm_d3,
`endif
   output logic [DQ_WIDTH-1:0]   dq_d0,
   output logic [DQ_WIDTH-1:0]   dq_d1,
   output logic [DQ_WIDTH-1:0]   dq_d2,
   output logic [DQ_WIDTH-1:0]   dq_d3,
   output logic [DQS_WIDTH-1:0]  dqs_d0,
   output logic [DQS_WIDTH-1:0]  dqs_d1,
   output logic [DQS_WIDTH-1:0]  dqs_d2,
   output logic [DQS_WIDTH-1:0]  dqs_d3,
   output logic                  dq_oe,
   output logic                  dqs_oe,
   output logic                  wr_idle
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_PRE   = 3'd1;
   localparam logic [2:0] ST_BEAT0 = 3'd2;
   localparam logic [2:0] ST_BEAT1 = 3'd3;
   localparam logic [2:0] ST_POST  = 3'd4;

   logic [8*DQ_WIDTH-1:0] data_mem_r [FIFO_DEPTH];
   logic [8*DQ_WIDTH-1:0] burst_r;
   logic [8*DQ_WIDTH-1:0] head_s;
   logic [PTR_W-1:0]      wptr_r, rptr_r;
   logic [PTR_W:0]        count_r, count_nxt_s;
   logic [2:0]            state_r, state_nxt_s;
   logic                  full_s, push_s, pop_s, beat_nxt_s;
`ifdef DDR3_WR_DM_EN
   logic [8*DM_WIDTH-1:0] mask_mem_r [FIFO_DEPTH];
   logic [8*DM_WIDTH-1:0] burst_mask_r;
   logic [8*DM_WIDTH-1:0] head_mask_s;
   assign head_mask_s = mask_mem_r[rptr_r];
`endif

   // Full is judged on the registered count, so a same-cycle pop lifts it only next cycle.
   assign full_s   = (count_r == DEPTH_C);
   assign wr_ready = ~full_s & ~rstb;
   assign push_s   = wr_valid & wr_ready;
   assign head_s   = data_mem_r[rptr_r];

   // Next-state and pop decision; IDLE/POST also react to a push landing this cycle.
   always_comb begin
      state_nxt_s = state_r;
      pop_s       = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if ((count_r != '0) || push_s) state_nxt_s = ST_PRE;
            else                           state_nxt_s = ST_IDLE;
         end
         ST_PRE: begin
            state_nxt_s = ST_BEAT0;
            pop_s       = 1'b1;
         end
         ST_BEAT0: state_nxt_s = ST_BEAT1;
         ST_BEAT1: begin
            if (count_r != '0) begin
               state_nxt_s = ST_BEAT0;
               pop_s       = 1'b1;
            end else begin
               state_nxt_s = ST_POST;
            end
         end
         ST_POST: begin
            if ((count_r != '0) || push_s) state_nxt_s = ST_PRE;
            else                           state_nxt_s = ST_IDLE;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Occupancy update from push/pop.
   always_comb begin
      count_nxt_s = count_r;
      if (push_s && !pop_s)      count_nxt_s = count_r + CNT_ONE;
      else if (!push_s && pop_s) count_nxt_s = count_r - CNT_ONE;
      else                       count_nxt_s = count_r;
      beat_nxt_s = (state_nxt_s == ST_BEAT0) || (state_nxt_s == ST_BEAT1);
   end

   // FIFO storage; entries are not cleared on reset since pointers define validity.
   always_ff @(posedge sclk) begin
      if (push_s) begin
         data_mem_r[wptr_r] <= wr_data;
`ifdef DDR3_WR_DM_EN
         mask_mem_r[wptr_r] <= wr_mask;
`endif
      end
   end

   // Pointers, FSM and flopped gearing outputs.
   always_ff @(posedge sclk) begin
      if (rstb) begin
         wptr_r  <= '0;
         rptr_r  <= '0;
         count_r <= '0;
         state_r <= ST_IDLE;
         burst_r <= '0;
         dq_d0   <= '0;
         dq_d1   <= '0;
         dq_d2   <= '0;
         dq_d3   <= '0;
         dqs_d0  <= '0;
         dqs_d1  <= '0;
         dqs_d2  <= '0;
         dqs_d3  <= '0;
         dq_oe   <= 1'b0;
         dqs_oe  <= 1'b0;
         wr_idle <= 1'b1;
`ifdef DDR3_WR_DM_EN
         burst_mask_r <= '0;
         dm_d0 <= '0;
         dm_d1 <= '0;
         dm_d2 <= '0;
         dm_d3 <= '0;
`endif
      end else begin
         if (push_s) wptr_r <= wptr_r + PTR_ONE;
         if (pop_s)  rptr_r <= rptr_r + PTR_ONE;
         count_r <= count_nxt_s;
         state_r <= state_nxt_s;
         dq_oe   <= beat_nxt_s;
         dqs_oe  <= (state_nxt_s != ST_IDLE);
         wr_idle <= (state_nxt_s == ST_IDLE) && (count_nxt_s == '0);
         // First half goes straight from the FIFO head; the burst register feeds the second.
         if (pop_s) begin
            burst_r <= head_s;
            dq_d0   <= head_s[0*DQ_WIDTH +: DQ_WIDTH];
            dq_d1   <= head_s[1*DQ_WIDTH +: DQ_WIDTH];
            dq_d2   <= head_s[2*DQ_WIDTH +: DQ_WIDTH];
            dq_d3   <= head_s[3*DQ_WIDTH +: DQ_WIDTH];
`ifdef DDR3_WR_DM_EN
            burst_mask_r <= head_mask_s;
            dm_d0 <= head_mask_s[0*DM_WIDTH +: DM_WIDTH];
            dm_d1 <= head_mask_s[1*DM_WIDTH +: DM_WIDTH];
            dm_d2 <= head_mask_s[2*DM_WIDTH +: DM_WIDTH];
            dm_d3 <= head_mask_s[3*DM_WIDTH +: DM_WIDTH];
`endif
         end else if (state_nxt_s == ST_BEAT1) begin
            dq_d0 <= burst_r[4*DQ_WIDTH +: DQ_WIDTH];
            dq_d1 <= burst_r[5*DQ_WIDTH +: DQ_WIDTH];
            dq_d2 <= burst_r[6*DQ_WIDTH +: DQ_WIDTH];
            dq_d3 <= burst_r[7*DQ_WIDTH +: DQ_WIDTH];
`ifdef DDR3_WR_DM_EN
            dm_d0 <= burst_mask_r[4*DM_WIDTH +: DM_WIDTH];
            dm_d1 <= burst_mask_r[5*DM_WIDTH +: DM_WIDTH];
            dm_d2 <= burst_mask_r[6*DM_WIDTH +: DM_WIDTH];
            dm_d3 <= burst_mask_r[7*DM_WIDTH +: DM_WIDTH];
`endif
         end
         if (beat_nxt_s) begin
            dqs_d0 <= {DQS_WIDTH{1'b1}};
            dqs_d1 <= {DQS_WIDTH{1'b0}};
            dqs_d2 <= {DQS_WIDTH{1'b1}};
            dqs_d3 <= {DQS_WIDTH{1'b0}};
         end else begin
            dqs_d0 <= {DQS_WIDTH{1'b0}};
            dqs_d1 <= {DQS_WIDTH{1'b0}};
            dqs_d2 <= {DQS_WIDTH{1'b0}};
            dqs_d3 <= {DQS_WIDTH{1'b0}};
         end
      end
   end

endmodule

// File: tb/tb_ddr3_wr_gearbox.sv
// Scoreboard bench for ddr3_wr_gearbox: accepted bursts are queued as expected output,
// a negedge monitor pops and compares each burst as the DUT drives it.
module tb_ddr3_wr_gearbox;
   localparam int DQ  = 16;
   localparam int DM  = 2;
   localparam int DQS = 2;
   localparam int BW  = 8*DQ;

   logic sclk = 1'b0;
   logic rstb = 1'b1;
   logic wr_valid = 1'b0;
   logic wr_ready;
   logic [BW-1:0]   wr_data = '0;
   logic [8*DM-1:0] wr_mask = '0;
   logic [DQ-1:0]   dq_d0, dq_d1, dq_d2, dq_d3;
   logic [DQS-1:0]  dqs_d0, dqs_d1, dqs_d2, dqs_d3;
   logic            dq_oe, dqs_oe, wr_idle;
`ifdef DDR3_WR_DM_EN
   logic [DM-1:0]   dm_d0, dm_d1, dm_d2, dm_d3;
`endif

   always #5 sclk = ~sclk;

   ddr3_wr_gearbox #(.DQ_WIDTH(DQ), .FIFO_DEPTH(4)) dut (
      .sclk(sclk), .rstb(rstb), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
`ifdef DDR3_WR_DM_EN
      .wr_mask(wr_mask), .dm_d0(dm_d0), .dm_d1(dm_d1), .dm_d2(dm_d2), .dm_d3(dm_d3),
`endif
      .dq_d0(dq_d0), .dq_d1(dq_d1), .dq_d2(dq_d2), .dq_d3(dq_d3),
      .dqs_d0(dqs_d0), .dqs_d1(dqs_d1), .dqs_d2(dqs_d2), .dqs_d3(dqs_d3),
      .dq_oe(dq_oe), .dqs_oe(dqs_oe), .wr_idle(wr_idle)
   );

   int checks = 0;
   int failures = 0;
   logic [8*DM+BW-1:0] exp_q [$];
   logic [8*DM+BW-1:0] cur = '0;
   bit   phase = 1'b0;
   bit   mon_on = 1'b0;
   bit   win = 1'b0;
   int   cnt_dq, cnt_dqs, rise_dq, rise_dqs;
   logic prev_dq = 1'b0, prev_dqs = 1'b0;

   task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [BW-1:0] pat1();
      logic [BW-1:0] r;
      for (int b = 0; b < 8; b++) r[b*DQ +: DQ] = 16'h1111 * 16'(b);
      return r;
   endfunction

   function automatic logic [BW-1:0] mk(input logic [7:0] tag);
      logic [BW-1:0] r;
      for (int b = 0; b < 8; b++) r[b*DQ +: DQ] = {tag, 4'hC, 4'(b)};
      return r;
   endfunction

   task automatic send(input logic [BW-1:0] d, input logic [8*DM-1:0] m, output int stalls);
      int  n;
      bit  acc;
      n = 0;
      acc = 1'b0;
      wr_valid = 1'b1;
      wr_data  = d;
      wr_mask  = m;
      while (!acc && n < 50) begin
         @(negedge sclk);
         acc = wr_ready;
         @(posedge sclk);
         #1;
         n++;
      end
      wr_valid = 1'b0;
      stalls = n - 1;
      if (acc) begin
         exp_q.push_back({m, d});
      end else begin
         checks++;
         failures++;
         $display("FAIL send_timeout actual=no_accept required=accept");
      end
   endtask

   task automatic expect_oe(input string nm, input logic dq, input logic dqs, input logic idle);
      @(negedge sclk);
      chk(nm, {dq_oe, dqs_oe, wr_idle}, {dq, dqs, idle});
   endtask

   task automatic wait_idle(input string nm);
      int n;
      n = 0;
      @(negedge sclk);
      while (!(wr_idle && exp_q.size() == 0 && !dqs_oe) && n < 300) begin
         @(negedge sclk);
         n++;
      end
      chk({nm, "_drained"}, BW'(exp_q.size()), BW'(0));
      chk({nm, "_idle"}, BW'(wr_idle), BW'(1));
   endtask

   task automatic clear_stats();
      cnt_dq = 0;
      cnt_dqs = 0;
      rise_dq = 0;
      rise_dqs = 0;
   endtask

   // Output monitor and scoreboard comparison.
   always @(negedge sclk) begin
      if (win) begin
         if (dq_oe) cnt_dq++;
         if (dqs_oe) cnt_dqs++;
         if (dq_oe && !prev_dq) rise_dq++;
         if (dqs_oe && !prev_dqs) rise_dqs++;
      end
      prev_dq  = dq_oe;
      prev_dqs = dqs_oe;
      if (mon_on && !rstb) begin
         if (dq_oe) begin
            if (!phase) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL sb_unexpected actual=burst required=none");
                  cur = '0;
               end else begin
                  cur = exp_q.pop_front();
               end
            end
            chk(phase ? "sb_dq_hi" : "sb_dq_lo", BW'({dq_d3, dq_d2, dq_d1, dq_d0}),
                phase ? BW'(cur[127:64]) : BW'(cur[63:0]));
`ifdef DDR3_WR_DM_EN
            chk(phase ? "sb_dm_hi" : "sb_dm_lo", BW'({dm_d3, dm_d2, dm_d1, dm_d0}),
                phase ? BW'(cur[BW+8 +: 8]) : BW'(cur[BW +: 8]));
`endif
            chk("sb_dqs", BW'({dqs_oe, dqs_d3, dqs_d2, dqs_d1, dqs_d0}), BW'({1'b1, 8'h33}));
            phase = ~phase;
         end else begin
            chk("sb_dqs_quiet", BW'({dqs_d3, dqs_d2, dqs_d1, dqs_d0}), BW'(0));
            chk("sb_half_burst", BW'(phase), BW'(0));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int st, tot;
      clear_stats();
      repeat (3) @(posedge sclk);
      @(negedge sclk);
      chk("rst_ready_low", BW'(wr_ready), BW'(0));
      @(posedge sclk);
      #1;
      rstb = 1'b0;
      @(negedge sclk);
      chk("rst_oe_idle", BW'({dq_oe, dqs_oe, wr_idle, wr_ready}), BW'(4'b0011));
      chk("rst_dq", BW'({dq_d3, dq_d2, dq_d1, dq_d0}), BW'(0));
      chk("rst_dqs", BW'({dqs_d3, dqs_d2, dqs_d1, dqs_d0}), BW'(0));
      mon_on = 1'b1;
      @(posedge sclk);
      #1;

      // 1: single burst latency and data
      send(pat1(), 16'h0000, st);
      expect_oe("t1_pre", 1'b0, 1'b1, 1'b0);
      expect_oe("t1_beat0", 1'b1, 1'b1, 1'b0);
      chk("t1_dq_beat0", BW'({dq_d3, dq_d2, dq_d1, dq_d0}), BW'(64'h3333_2222_1111_0000));
      expect_oe("t1_beat1", 1'b1, 1'b1, 1'b0);
      chk("t1_dq_beat1", BW'({dq_d3, dq_d2, dq_d1, dq_d0}), BW'(64'h7777_6666_5555_4444));
      expect_oe("t1_post", 1'b0, 1'b1, 1'b0);
      chk("t1_dq_hold", BW'({dq_d3, dq_d2, dq_d1, dq_d0}), BW'(64'h7777_6666_5555_4444));
      expect_oe("t1_idle", 1'b0, 1'b0, 1'b1);
      @(posedge sclk);
      #1;

      // 2: three back-to-back bursts stream seamlessly
      clear_stats();
      win = 1'b1;
      for (int i = 0; i < 3; i++) send(mk(8'(1 + i)), 16'h0000, st);
      wait_idle("t2");
      win = 1'b0;
      chk("t2_dq_cycles", BW'(cnt_dq), BW'(6));
      chk("t2_dqs_cycles", BW'(cnt_dqs), BW'(8));
      chk("t2_dq_gapless", BW'(rise_dq), BW'(1));
      @(posedge sclk);
      #1;

      // 3: fill the FIFO while streaming; the 8th offer waits one cycle
      tot = 0;
      for (int i = 0; i < 7; i++) begin
         send(mk(8'(16 + i)), 16'h0000, st);
         tot += st;
      end
      chk("t3_no_early_stall", BW'(tot), BW'(0));
      send(mk(8'd23), 16'h0000, st);
      chk("t3_full_stall", BW'(st), BW'(1));
      send(mk(8'd24), 16'h0000, st);
      wait_idle("t3");
      @(posedge sclk);
      #1;

      // 4: push during POST keeps dqs_oe continuous
      clear_stats();
      win = 1'b1;
      send(mk(8'd32), 16'h0000, st);
      repeat (3) begin
         @(posedge sclk);
         #1;
      end
      send(mk(8'd33), 16'h0000, st);
      expect_oe("t4_pre", 1'b0, 1'b1, 1'b0);
      expect_oe("t4_beat0", 1'b1, 1'b1, 1'b0);
      wait_idle("t4");
      win = 1'b0;
      chk("t4_dq_cycles", BW'(cnt_dq), BW'(4));
      chk("t4_dqs_cycles", BW'(cnt_dqs), BW'(8));
      chk("t4_dqs_continuous", BW'(rise_dqs), BW'(1));
      @(posedge sclk);
      #1;

      // 5: reset in BEAT0 with two bursts queued
      for (int i = 0; i < 4; i++) send(mk(8'(40 + i)), 16'h0000, st);
      rstb = 1'b1;
      @(posedge sclk);
      #1;
      rstb = 1'b0;
      exp_q.delete();
      phase = 1'b0;
      @(negedge sclk);
      chk("t5_after_rst", BW'({dq_oe, dqs_oe, wr_idle, wr_ready}), BW'(4'b0011));
      chk("t5_dq_zero", BW'({dq_d3, dq_d2, dq_d1, dq_d0}), BW'(0));
      expect_oe("t5_stays_idle", 1'b0, 1'b0, 1'b1);
      @(posedge sclk);
      #1;
      send(mk(8'd50), 16'h0000, st);
      wait_idle("t5");
      @(posedge sclk);
      #1;

`ifdef DDR3_WR_DM_EN
      // 6: mask beat 3 = 2'b01
      send(pat1(), 16'h0040, st);
      expect_oe("t6_pre", 1'b0, 1'b1, 1'b0);
      expect_oe("t6_beat0", 1'b1, 1'b1, 1'b0);
      chk("t6_dm_beat0", BW'({dm_d3, dm_d2, dm_d1, dm_d0}), BW'(8'b01_00_00_00));
      expect_oe("t6_beat1", 1'b1, 1'b1, 1'b0);
      chk("t6_dm_beat1", BW'({dm_d3, dm_d2, dm_d1, dm_d0}), BW'(8'h00));
      wait_idle("t6");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
